// File: rtl/req_index_arbiter.sv
// Round-robin request arbiter feeding a small index FIFO with valid/ready output.
// Define REQ_INDEX_ARBITER_STATS_EN to enable the 16-bit grant counter on gnt_cnt_o.

package common_pkg;
  parameter int TEST_PARAM = 4;
endpackage

module req_index_arbiter #(
  parameter int NUM_REQ    = common_pkg::TEST_PARAM,
  parameter int FIFO_DEPTH = 4,
  parameter int IDX_W      = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic [NUM_REQ-1:0]            req_i,
  output logic [NUM_REQ-1:0]            gnt_o,
  input  logic                          flush_i,
  output logic [IDX_W-1:0]              aa_o,
  output logic                          a_o,
  input  logic                          ready_i,
  output logic                          full_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic [15:0]                   gnt_cnt_o
);

  localparam int ADDR_W = $clog2(FIFO_DEPTH);
  localparam int PTR_W  = ADDR_W + 1;

  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [IDX_W-1:0]   last_reg, last_next;
  logic [IDX_W-1:0]   aa_reg, aa_next;
  logic [IDX_W-1:0]   mem [FIFO_DEPTH];

  logic               empty;
  logic               full;
  logic [PTR_W-1:0]   level;
  logic               pop;
  logic               push_ok;
  logic               push;
  logic [ADDR_W-1:0]  wr_addr;
  logic [ADDR_W-1:0]  rd_addr_after;

  logic [NUM_REQ-1:0] masked_req;
  logic [NUM_REQ-1:0] pick_req;
  logic [NUM_REQ-1:0] onehot;
  logic [IDX_W-1:0]   winner;

  // FIFO status from the extra-MSB pointer scheme
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[ADDR_W] != rd_ptr_reg[ADDR_W]) &&
                   (wr_ptr_reg[ADDR_W-1:0] == rd_ptr_reg[ADDR_W-1:0]);
  assign level   = wr_ptr_reg - rd_ptr_reg;
  assign pop     = !empty && ready_i && !flush_i;
  assign push_ok = !full || (!empty && ready_i);
  assign push    = (|req_i) && push_ok && !flush_i && !rst_i;

  assign wr_addr       = wr_ptr_reg[ADDR_W-1:0];
  assign rd_addr_after = rd_ptr_reg[ADDR_W-1:0] + ADDR_W'(1);

  // Requests above the last winner get first pick; otherwise wrap to the full set
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_mask
      assign masked_req[gi] = req_i[gi] & (gi > int'(last_reg));
    end
  endgenerate

  assign pick_req = (|masked_req) ? masked_req : req_i;

  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_lowest
      if (gi == 0) begin : g_first
        assign onehot[gi] = pick_req[gi];
      end else begin : g_rest
        assign onehot[gi] = pick_req[gi] & ~(|pick_req[gi-1:0]);
      end
    end
  endgenerate

  always_comb begin
    winner = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (onehot[i]) begin
        winner = winner | IDX_W'(i);
      end
    end
  end

  assign gnt_o = push ? onehot : '0;

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    last_next   = last_reg;
    aa_next     = aa_reg;
    if (flush_i) begin
      rd_ptr_next = wr_ptr_reg;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + PTR_W'(1);
        last_next   = winner;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_W'(1);
      end
      // Head register tracks the entry that will sit at rd_ptr after this edge
      if (empty && push) begin
        aa_next = winner;
      end else if (pop && (level > PTR_W'(1))) begin
        aa_next = mem[rd_addr_after];
      end else if (pop && push && (level == PTR_W'(1))) begin
        aa_next = winner;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      last_reg   <= IDX_W'(NUM_REQ - 1);
      aa_reg     <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      last_reg   <= last_next;
      aa_reg     <= aa_next;
    end
  end

  // Storage array has no reset so it can map onto distributed/block RAM
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_addr] <= winner;
    end
  end

  assign aa_o    = aa_reg;
  assign a_o     = !empty;
  assign full_o  = full;
  assign level_o = level;

`ifdef REQ_INDEX_ARBITER_STATS_EN
  logic [15:0] gnt_cnt_reg;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_cnt_reg <= '0;
    end else if (push) begin
      gnt_cnt_reg <= gnt_cnt_reg + 16'd1;
    end
  end

  assign gnt_cnt_o = gnt_cnt_reg;
`else
  assign gnt_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_req_index_arbiter.sv
// Directed bench for req_index_arbiter with a queue scoreboard checking popped indices.
module tb_req_index_arbiter;

  localparam int N = 4;
  localparam int D = 4;

  logic         clk_i = 1'b0;
  logic         rst_i = 1'b1;
  logic [N-1:0] req_i = '0;
  logic [N-1:0] gnt_o;
  logic         flush_i = 1'b0;
  logic [1:0]   aa_o;
  logic         a_o;
  logic         ready_i = 1'b0;
  logic         full_o;
  logic [2:0]   level_o;
  logic [15:0]  gnt_cnt_o;

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];
  int exp_cnt = 0;
  int mon_exp;

  req_index_arbiter #(.NUM_REQ(N), .FIFO_DEPTH(D)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (req_i),
    .gnt_o     (gnt_o),
    .flush_i   (flush_i),
    .aa_o      (aa_o),
    .a_o       (a_o),
    .ready_i   (ready_i),
    .full_o    (full_o),
    .level_o   (level_o),
    .gnt_cnt_o (gnt_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Apply inputs just after a rising edge, then return at the falling edge for sampling
  task automatic drive(input logic [N-1:0] r, input logic rd, input logic fl);
    @(posedge clk_i);
    #1;
    req_i   = r;
    ready_i = rd;
    flush_i = fl;
    @(negedge clk_i);
  endtask

  task automatic expect_grant(input string name, input logic [N-1:0] g, input int idx);
    check(name, gnt_o, g);
    exp_q.push_back(idx);
    exp_cnt++;
    $display("grant %s gnt_o=%b idx=%0d", name, gnt_o, idx);
  endtask

  task automatic check_cnt(input string name);
`ifdef REQ_INDEX_ARBITER_STATS_EN
    check(name, gnt_cnt_o, exp_cnt & 32'hFFFF);
`else
    check(name, gnt_cnt_o, 0);
`endif
  endtask

  task automatic drain(input string name);
    drive('0, 1'b1, 1'b0);
    for (int k = 0; k < 16 && a_o; k++) begin
      drive('0, 1'b1, 1'b0);
    end
    check({name, "_empty"}, a_o, 0);
  endtask

  // Monitor: every accepted transfer pops the next expected index
  always @(negedge clk_i) begin
    if (!rst_i && a_o && ready_i && !flush_i) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL pop_unexpected: got aa_o=%0d required no entry", aa_o);
      end else begin
        mon_exp = exp_q.pop_front();
        check("pop_aa", aa_o, mon_exp);
        $display("pop aa_o=%0d exp=%0d", aa_o, mon_exp);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout required $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_level", level_o, 0);
    check("rst_a", a_o, 0);
    check("rst_aa", aa_o, 0);
    check("rst_full", full_o, 0);
    check("rst_gnt", gnt_o, 0);
    check_cnt("rst_cnt");
    @(posedge clk_i);
    #1 rst_i = 1'b0;

    // 1: all requesting, downstream always ready
    drive(4'b1111, 1'b1, 1'b0);
    check("t1_a0", a_o, 0);
    expect_grant("t1_g0", 4'b0001, 0);
    drive(4'b1111, 1'b1, 1'b0);
    check("t1_a1", a_o, 1);
    check("t1_lvl1", level_o, 1);
    expect_grant("t1_g1", 4'b0010, 1);
    drive(4'b1111, 1'b1, 1'b0);
    expect_grant("t1_g2", 4'b0100, 2);
    drive(4'b1111, 1'b1, 1'b0);
    expect_grant("t1_g3", 4'b1000, 3);
    drive(4'b1111, 1'b1, 1'b0);
    check("t1_lvl4", level_o, 1);
    expect_grant("t1_g4", 4'b0001, 0);
    drain("t1");

    // 2: fill to full with downstream stalled
    drive(4'b1010, 1'b0, 1'b0);
    expect_grant("t2_g0", 4'b0010, 1);
    drive(4'b1010, 1'b0, 1'b0);
    expect_grant("t2_g1", 4'b1000, 3);
    drive(4'b1010, 1'b0, 1'b0);
    expect_grant("t2_g2", 4'b0010, 1);
    drive(4'b1010, 1'b0, 1'b0);
    check("t2_lvl3", level_o, 3);
    check("t2_nfull", full_o, 0);
    expect_grant("t2_g3", 4'b1000, 3);
    drive(4'b1010, 1'b0, 1'b0);
    check("t2_full", full_o, 1);
    check("t2_lvl_full", level_o, 4);
    check("t2_nogrant", gnt_o, 0);
    drive(4'b1010, 1'b1, 1'b0);
    expect_grant("t2_pushpop", 4'b0010, 1);
    check("t2_lvl_pp", level_o, 4);

    // 3: drain a full FIFO
    drive('0, 1'b1, 1'b0);
    check("t3_lvl4", level_o, 4);
    check("t3_gnt", gnt_o, 0);
    drive('0, 1'b1, 1'b0);
    check("t3_lvl3", level_o, 3);
    drive('0, 1'b1, 1'b0);
    check("t3_lvl2", level_o, 2);
    drive('0, 1'b1, 1'b0);
    check("t3_lvl1", level_o, 1);
    drive('0, 1'b1, 1'b0);
    check("t3_lvl0", level_o, 0);
    check("t3_a", a_o, 0);
    drive('0, 1'b1, 1'b0);
    check("t3_idle_lvl", level_o, 0);
    check("t3_stale_aa", aa_o, 1);

    // 4: flush at level 3
    drive(4'b0001, 1'b0, 1'b0);
    expect_grant("t4_g0", 4'b0001, 0);
    drive(4'b0001, 1'b0, 1'b0);
    expect_grant("t4_g1", 4'b0001, 0);
    drive(4'b0001, 1'b0, 1'b0);
    expect_grant("t4_g2", 4'b0001, 0);
    drive(4'b0001, 1'b0, 1'b1);
    check("t4_lvl3", level_o, 3);
    check("t4_flush_gnt", gnt_o, 0);
    exp_q.delete();
    drive(4'b0001, 1'b0, 1'b0);
    check("t4_lvl_flushed", level_o, 0);
    check("t4_a_flushed", a_o, 0);
    expect_grant("t4_after", 4'b0001, 0);
    drive('0, 1'b0, 1'b0);
    check("t4_lvl_after", level_o, 1);
    check("t4_a_after", a_o, 1);
    check("t4_aa_after", aa_o, 0);
    drain("t4");
    check_cnt("t4_cnt");

    // 5: asynchronous reset with two entries queued
    drive(4'b0100, 1'b0, 1'b0);
    expect_grant("t5_g0", 4'b0100, 2);
    drive(4'b0100, 1'b0, 1'b0);
    expect_grant("t5_g1", 4'b0100, 2);
    drive('0, 1'b0, 1'b0);
    check("t5_lvl2", level_o, 2);
    #2;
    req_i = 4'b1100;
    rst_i = 1'b1;
    #1;
    check("t5_rst_lvl", level_o, 0);
    check("t5_rst_a", a_o, 0);
    check("t5_rst_aa", aa_o, 0);
    check("t5_rst_full", full_o, 0);
    check("t5_rst_gnt", gnt_o, 0);
    exp_q.delete();
    exp_cnt = 0;
    check_cnt("t5_rst_cnt");
    @(posedge clk_i);
    #3 rst_i = 1'b0;
    @(negedge clk_i);
    expect_grant("t5_first", 4'b0100, 2);
    drain("t5");
    check_cnt("t5_cnt");

`ifdef REQ_INDEX_ARBITER_STATS_EN
    // 6: counter wrap after 65537 grants since reset
    for (int i = 0; i < 65536; i++) begin
      @(posedge clk_i);
      #1;
      req_i   = 4'b0001;
      ready_i = 1'b1;
      exp_q.push_back(0);
      exp_cnt++;
    end
    drain("t6");
    check("t6_wrap", gnt_cnt_o, 1);
`endif

    check("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
